// File: rtl/acc_pkg.sv
// Shared types and constants for the accumulator bank.
package acc_pkg;

    localparam int unsigned OP_W    = 3;
    localparam int unsigned RST_VAL = 0;

    // Operation codes sampled with op_start_i.
    typedef enum logic [OP_W-1:0] {
        OpNop = 3'b000,
        OpClr = 3'b001,
        OpInc = 3'b010,
        OpDec = 3'b011,
        OpShl = 3'b100,
        OpShr = 3'b101,
        OpRol = 3'b110,
        OpRor = 3'b111
    } op_t;

    // Control FSM states.
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_t;

endpackage

// File: rtl/acc_shift_step.sv
// Single-bit shift/rotate step: one bit position of SHL/SHR/ROL/ROR per use.
module acc_shift_step
    import acc_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] val_i,
    input  op_t              op_i,
    output logic [WIDTH-1:0] val_o,
    output logic             out_o
);

    // Move the value by one position; out_o is the bit that leaves the word.
    always_comb begin
        val_o = val_i;
        out_o = 1'b0;
        case (op_i)
            OpShl: begin
                val_o = {val_i[WIDTH-2:0], 1'b0};
                out_o = val_i[WIDTH-1];
            end
            OpShr: begin
                val_o = {1'b0, val_i[WIDTH-1:1]};
                out_o = val_i[0];
            end
            OpRol: begin
                val_o = {val_i[WIDTH-2:0], val_i[WIDTH-1]};
                out_o = val_i[WIDTH-1];
            end
            OpRor: begin
                val_o = {val_i[0], val_i[WIDTH-1:1]};
                out_o = val_i[0];
            end
            default: begin
                val_o = val_i;
                out_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/acc_bank.sv
// Bank of NREG accumulators with W-bus load/drive, single-cycle arithmetic ops
// and multi-cycle shift/rotate with a busy/done handshake.
// Optional build macro ACC_SAT_EN: INC/DEC saturate instead of wrapping.
module acc_bank
    import acc_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREG  = 2,
    parameter int unsigned SELW  = (NREG > 1) ? $clog2(NREG) : 1,
    parameter int unsigned AMTW  = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
    input  logic             clk_i,
    input  logic             nclr_ni,
    input  logic             nla_ni,
    input  logic             ea_i,
    input  logic [SELW-1:0]  sel_i,
    input  logic [OP_W-1:0]  op_i,
    input  logic             op_start_i,
    input  logic [AMTW-1:0]  amt_i,
    input  logic [WIDTH-1:0] bus_in_i,
    output tri   [WIDTH-1:0] bus_out_o,
    output logic [WIDTH-1:0] atemp_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             zero_f_o,
    output logic             neg_f_o,
    output logic             carry_f_o
);

    logic [WIDTH-1:0] regs_q [NREG];

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [SELW-1:0]  sel_q, sel_d;
    logic [AMTW-1:0]  cnt_q, cnt_d;
    logic             zero_q, neg_q, carry_q;

    logic             wr_en;
    logic [SELW-1:0]  wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic             carry_we;
    logic             carry_val;

    logic             sel_valid;
    logic [WIDTH-1:0] sel_val;
    logic [WIDTH-1:0] sh_val;
    logic [WIDTH-1:0] step_res;
    logic             step_out;

    logic [WIDTH:0]   inc_sum, dec_diff;
    logic [WIDTH-1:0] inc_res, dec_res;
    logic             inc_c, dec_c;

    // Read muxes: the externally selected register and the one being shifted.
    always_comb begin
        sel_valid = 1'b0;
        sel_val   = '0;
        sh_val    = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            if (sel_i == SELW'(i)) begin
                sel_valid = 1'b1;
                sel_val   = regs_q[i];
            end
            if (sel_q == SELW'(i)) begin
                sh_val = regs_q[i];
            end
        end
    end

    acc_shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .val_i (sh_val),
        .op_i  (op_q),
        .val_o (step_res),
        .out_o (step_out)
    );

    // INC/DEC results; the extra top bit is carry-out or borrow.
    always_comb begin
        inc_sum  = {1'b0, sel_val} + (WIDTH+1)'(1);
        dec_diff = {1'b0, sel_val} - (WIDTH+1)'(1);
`ifdef ACC_SAT_EN
        inc_res  = inc_sum[WIDTH] ? sel_val : inc_sum[WIDTH-1:0];
        dec_res  = dec_diff[WIDTH] ? sel_val : dec_diff[WIDTH-1:0];
`else
        inc_res  = inc_sum[WIDTH-1:0];
        dec_res  = dec_diff[WIDTH-1:0];
`endif
        inc_c    = inc_sum[WIDTH];
        dec_c    = dec_diff[WIDTH];
    end

    // Next-state, register write port and flag updates.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        wr_en     = 1'b0;
        wr_idx    = sel_i;
        wr_data   = sel_val;
        carry_we  = 1'b0;
        carry_val = 1'b0;

        case (state_q)
            StIdle: begin
                if (!nla_ni) begin
                    // Load wins over a simultaneous op request.
                    wr_en   = sel_valid;
                    wr_data = bus_in_i;
                end else if (op_start_i) begin
                    op_d     = op_t'(op_i);
                    sel_d    = sel_i;
                    cnt_d    = amt_i;
                    state_d  = StDone;
                    wr_en    = sel_valid;
                    carry_we = sel_valid;
                    unique case (op_t'(op_i))
                        OpNop: begin
                            wr_data   = sel_val;
                            carry_val = 1'b0;
                        end
                        OpClr: begin
                            wr_data   = '0;
                            carry_val = 1'b0;
                        end
                        OpInc: begin
                            wr_data   = inc_res;
                            carry_val = inc_c;
                        end
                        OpDec: begin
                            wr_data   = dec_res;
                            carry_val = dec_c;
                        end
                        OpShl, OpShr, OpRol, OpRor: begin
                            if (amt_i != '0 && sel_valid) begin
                                // Result is committed bit by bit from SHIFT.
                                state_d  = StShift;
                                wr_en    = 1'b0;
                                carry_we = 1'b0;
                            end else begin
                                // Zero count degenerates to NOP.
                                wr_data   = sel_val;
                                carry_val = 1'b0;
                            end
                        end
                    endcase
                end
            end
            StShift: begin
                wr_en     = 1'b1;
                wr_idx    = sel_q;
                wr_data   = step_res;
                carry_we  = 1'b1;
                carry_val = step_out;
                cnt_d     = cnt_q - AMTW'(1);
                if (cnt_q == AMTW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Control state; reset aborts any shift in flight.
    always_ff @(posedge clk_i or negedge nclr_ni) begin
        if (!nclr_ni) begin
            state_q <= StIdle;
            op_q    <= OpNop;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    // Register bank write.
    always_ff @(posedge clk_i or negedge nclr_ni) begin
        if (!nclr_ni) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs_q[i] <= WIDTH'(RST_VAL);
            end
        end else if (wr_en) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                if (wr_idx == SELW'(i)) begin
                    regs_q[i] <= wr_data;
                end
            end
        end
    end

    // Global flags follow the most recent register write.
    always_ff @(posedge clk_i or negedge nclr_ni) begin
        if (!nclr_ni) begin
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            if (wr_en) begin
                zero_q <= (wr_data == '0);
                neg_q  <= wr_data[WIDTH-1];
            end
            if (carry_we) begin
                carry_q <= carry_val;
            end
        end
    end

    assign atemp_o   = sel_val;
    assign bus_out_o = (ea_i && state_q == StIdle) ? sel_val : {WIDTH{1'bz}};
    assign busy_o    = (state_q == StShift);
    assign done_o    = (state_q == StDone);
    assign zero_f_o  = zero_q;
    assign neg_f_o   = neg_q;
    assign carry_f_o = carry_q;

endmodule

// File: tb/tb_acc_bank.sv
// Randomized self-checking bench for acc_bank against a transaction-level model.
module tb_acc_bank;

    localparam int W  = 8;
    localparam int N  = 3;
    localparam int SW = 2;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          nclr, nla, ea, op_start;
    logic [SW-1:0] sel;
    logic [2:0]    op;
    logic [AW-1:0] amt;
    logic [W-1:0]  bus_in;
    tri   [W-1:0]  bus_out;
    logic [W-1:0]  atemp;
    logic          busy, done, zf, nf, cf;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_reg [4];
    logic       m_z, m_n, m_c;

    localparam logic [31:0] ZBUS = {24'h0, {8{1'bz}}};

    acc_bank #(
        .WIDTH (W),
        .NREG  (N)
    ) dut (
        .clk_i      (clk),
        .nclr_ni    (nclr),
        .nla_ni     (nla),
        .ea_i       (ea),
        .sel_i      (sel),
        .op_i       (op),
        .op_start_i (op_start),
        .amt_i      (amt),
        .bus_in_i   (bus_in),
        .bus_out_o  (bus_out),
        .atemp_o    (atemp),
        .busy_o     (busy),
        .done_o     (done),
        .zero_f_o   (zf),
        .neg_f_o    (nf),
        .carry_f_o  (cf)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
        m_z = 1'b0;
        m_n = 1'b0;
        m_c = 1'b0;
    endtask

    task automatic model_write(input int s, input logic [7:0] r);
        m_reg[s] = r;
        m_z = (r == 8'h00);
        m_n = r[7];
    endtask

    // Whole-operation result from the opcode rules, computed with plain arithmetic.
    task automatic model_op(input int o, input int s, input int a);
        int   v, r;
        logic c;
        if (s >= N) return;
        v = int'(m_reg[s]);
        r = v;
        c = 1'b0;
        case (o)
            0: r = v;
            1: r = 0;
            2: begin
`ifdef ACC_SAT_EN
                if (v == 255) begin r = 255; c = 1'b1; end else r = v + 1;
`else
                r = (v + 1) % 256;
                c = (v == 255);
`endif
            end
            3: begin
`ifdef ACC_SAT_EN
                if (v == 0) begin r = 0; c = 1'b1; end else r = v - 1;
`else
                r = (v + 255) % 256;
                c = (v == 0);
`endif
            end
            default: begin
                if (a != 0) begin
                    case (o)
                        4: begin r = (v << a) % 256; c = ((v >> (8 - a)) % 2) == 1; end
                        5: begin r = v >> a;         c = ((v >> (a - 1)) % 2) == 1; end
                        6: begin r = ((v << a) | (v >> (8 - a))) % 256; c = (r % 2) == 1; end
                        default: begin
                            r = ((v >> a) | (v << (8 - a))) % 256;
                            c = (r >= 128);
                        end
                    endcase
                end
            end
        endcase
        model_write(s, 8'(r));
        m_c = c;
    endtask

    // Observe every select through atemp and bus_out, plus the flags.
    task automatic check_state(input string tag);
        logic [7:0] e;
        for (int s = 0; s < 4; s++) begin
            sel = SW'(s);
            ea  = 1'b1;
            #1;
            e = (s < N) ? m_reg[s] : 8'h00;
            check($sformatf("%s.atemp%0d", tag, s), 32'(atemp), 32'(e));
            check($sformatf("%s.bus%0d", tag, s), {24'h0, bus_out}, 32'(e));
        end
        ea = 1'b0;
        #1;
        check({tag, ".busz"}, {24'h0, bus_out}, ZBUS);
        check({tag, ".flags"}, {29'h0, zf, nf, cf}, {29'h0, m_z, m_n, m_c});
    endtask

    task automatic do_load(input int s, input logic [7:0] v, input bit with_clr);
        sel      = SW'(s);
        bus_in   = v;
        nla      = 1'b0;
        op       = 3'b001;
        op_start = with_clr;
        tick();
        nla      = 1'b1;
        op_start = 1'b0;
        if (s < N) model_write(s, v);
        check("load.done0", 32'(done), 32'd0);
        tick();
        check("load.done1", 32'(done), 32'd0);
        check_state("load");
    endtask

    task automatic do_op(input int o, input int s, input int a, input bit poke);
        int cnt, exp_busy;
        sel      = SW'(s);
        op       = 3'(o);
        amt      = AW'(a);
        nla      = 1'b1;
        op_start = 1'b1;
        tick();
        op_start = 1'b0;
        exp_busy = (o >= 4 && a != 0 && s < N) ? a : 0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 20) begin
            if (cnt == 0) begin
                ea = 1'b1;
                #1;
                check("op.busz", {24'h0, bus_out}, ZBUS);
                ea = 1'b0;
                if (poke) begin
                    nla    = 1'b0;
                    bus_in = 8'hAA;
                end
            end
            tick();
            nla = 1'b1;
            cnt++;
        end
        check("op.busy_cycles", 32'(cnt), 32'(exp_busy));
        check("op.done", {30'h0, busy, done}, 32'd1);
        model_op(o, s, a);
        tick();
        check("op.done_clr", 32'(done), 32'd0);
        check_state("op");
    endtask

    initial begin
        nclr     = 1'b0;
        nla      = 1'b1;
        ea       = 1'b0;
        op_start = 1'b0;
        sel      = '0;
        op       = '0;
        amt      = '0;
        bus_in   = '0;
        model_reset();
        #12;
        check("rst.ctrl", {30'h0, busy, done}, 32'd0);
        check_state("rst");
        nclr = 1'b1;
        tick();

        // Directed cases.
        do_load(1, 8'h3C, 1'b0);
        do_load(0, 8'hFF, 1'b0);
        do_op(2, 0, 0, 1'b0);                // INC on all-ones
        do_load(0, 8'h81, 1'b0);
        do_op(6, 0, 3, 1'b0);                // ROL 3 -> 0C
        do_load(2, 8'h55, 1'b1);             // load beats CLR
        do_load(1, 8'hB6, 1'b0);
        do_op(5, 1, 4, 1'b1);                // load during busy SHR ignored
        do_op(4, 1, 0, 1'b0);                // SHL by 0
        do_load(0, 8'h00, 1'b0);
        do_op(3, 0, 0, 1'b0);                // DEC on zero
        do_op(2, 3, 0, 1'b0);                // out-of-range select
        do_op(7, 3, 5, 1'b0);
        do_load(3, 8'h77, 1'b0);

        // Abort a shift with reset.
        do_load(0, 8'hF0, 1'b0);
        do_load(1, 8'h5A, 1'b0);
        sel      = 2'd0;
        op       = 3'b101;
        amt      = 3'd7;
        op_start = 1'b1;
        tick();
        op_start = 1'b0;
        tick();
        tick();
        check("abort.busy_before", 32'(busy), 32'd1);
        nclr = 1'b0;
        #1;
        model_reset();
        check("abort.ctrl", {30'h0, busy, done}, 32'd0);
        check_state("abort");
        @(negedge clk);
        nclr = 1'b1;
        tick();
        check("abort.idle", {30'h0, busy, done}, 32'd0);

        // Random mix of loads and ops.
        for (int it = 0; it < 120; it++) begin
            int s;
            s = int'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin
                do_load(s, 8'($urandom), 1'($urandom_range(0, 1)));
            end else begin
                do_op(int'($urandom_range(0, 7)), s, int'($urandom_range(0, 7)),
                      1'($urandom_range(0, 1)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
